// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT encryption controller: one round per clock, valid/ready on both sides.
// Build option PRESENT_KEY128_EN selects the 128-bit key schedule (default is 80-bit).

module present_player (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  // Bit i moves to 16*i mod 63; bit 63 stays in place.
  for (genvar i = 0; i < 64; i++) begin : g_bit
    localparam int unsigned DST = (i == 63) ? 63 : (16 * i) % 63;
    assign dout[DST] = din[i];
  end
endmodule

module present_enc_ctrl #(
  parameter int unsigned ROUNDS = 31,
`ifdef PRESENT_KEY128_EN
  localparam int unsigned KW = 128
`else
  localparam int unsigned KW = 80
`endif
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [63:0]   data_i,
  input  logic [KW-1:0] key_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [63:0]   data_o,
  output logic          busy_o,
  output logic [4:0]    round_o
);

  if (ROUNDS != 31) begin : g_rounds_chk
    $error("present_enc_ctrl: ROUNDS must be 31");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  fsm_e          fsm_q, fsm_d;
  logic [63:0]   state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [63:0]   rk, sb_out, pl_out;
  logic [KW-1:0] key_rot, key_next;

  assign rk     = key_q[KW-1 -: 64];
  assign sb_out = sbox_layer(state_q ^ rk);

  present_player u_player (
    .din  (sb_out),
    .dout (pl_out)
  );

  // Key schedule step: rotate left 61, S-box the top nibble(s), fold in the round counter.
  always_comb begin
    key_rot  = {key_q[KW-62:0], key_q[KW-1:KW-61]};
    key_next = key_rot;
`ifdef PRESENT_KEY128_EN
    key_next[127:124] = sbox(key_rot[127:124]);
    key_next[123:120] = sbox(key_rot[123:120]);
    key_next[66:62]   = key_rot[66:62] ^ cnt_q;
`else
    key_next[79:76]   = sbox(key_rot[79:76]);
    key_next[19:15]   = key_rot[19:15] ^ cnt_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    data_o      = '0;
    busy_o      = 1'b1;
    round_o     = '0;
    unique case (fsm_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          state_d = data_i;
          key_d   = key_i;
          cnt_d   = 5'd1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        round_o = cnt_q;
        state_d = pl_out;
        key_d   = key_next;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(ROUNDS)) fsm_d = S_DONE;
      end
      S_DONE: begin
        // Final whitening with K32 is applied on the output path only.
        out_valid_o = 1'b1;
        data_o      = state_q ^ rk;
        if (out_ready_i) begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end
      end
      default: begin
        fsm_d  = S_IDLE;
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Directed testbench for present_enc_ctrl using published PRESENT test vectors.
// Build with PRESENT_KEY128_EN to exercise the 128-bit key variant.

module tb_present_enc_ctrl;
`ifdef PRESENT_KEY128_EN
  localparam int unsigned KW = 128;
  localparam logic [63:0] EXP_ZERO = 64'h96DB_702A_2E69_00AF;
`else
  localparam int unsigned KW = 80;
  localparam logic [63:0] EXP_ZERO = 64'h5579_C138_7B22_8445;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   data_i = '0;
  logic [KW-1:0] key_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   data_o;
  logic          busy;
  logic [4:0]    round;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  present_enc_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_i),
    .key_i       (key_i),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_o),
    .busy_o      (busy),
    .round_o     (round)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data act=%h exp=0", data_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy act=%b exp=0", busy); end
    checks++; if (round !== 5'd0) begin errors++; $display("FAIL reset_round act=%0d exp=0", round); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single job with the sink always ready; the accept edge counts as edge 1.
  task automatic do_job(input logic [63:0] pt, input logic [KW-1:0] key,
                        input logic [63:0] exp, input string name);
    int edges;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before act=%b exp=1", name, in_ready); end
    data_i = pt; key_i = key; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0; data_i = '0; key_i = '0;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    checks++; if (edges != 32) begin errors++; $display("FAIL %s_latency act=%0d exp=32", name, edges); end
    checks++; if (data_o !== exp) begin errors++; $display("FAIL %s_data act=%h exp=%h", name, data_o, exp); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_o !== 64'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release act=rdy%b vld%b busy%b data%h exp=rdy1 vld0 busy0 data0",
               name, in_ready, out_valid, busy, data_o);
    end
  endtask

  task automatic test_vectors();
`ifdef PRESENT_KEY128_EN
    do_job(64'h0, '0, EXP_ZERO, "k128_zero");
`else
    do_job(64'h0, '0, EXP_ZERO, "vec_zero");
    do_job(64'h0, '1, 64'hE72C_46C0_F594_5049, "vec_key_ones");
    do_job('1, '0, 64'hA112_FFC7_2F68_417B, "vec_pt_ones");
    do_job('1, '1, 64'h3333_DCD3_2132_10D2, "vec_all_ones");
`endif
  endtask

  task automatic test_backpressure();
    int n;
    bit stable_ok, ready_low;
    @(negedge clk);
    data_i = '0; key_i = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    checks++; if (data_o !== EXP_ZERO) begin errors++; $display("FAIL bp_data act=%h exp=%h", data_o, EXP_ZERO); end
    stable_ok = 1'b1; ready_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; data_i = 64'h0123_4567_89AB_CDEF; key_i = '1;
      @(posedge clk); @(negedge clk);
      if (data_o !== EXP_ZERO || out_valid !== 1'b1) stable_ok = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_low = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (!stable_ok) begin errors++; $display("FAIL bp_hold act=unstable exp=stable data %h", EXP_ZERO); end
    checks++; if (!ready_low) begin errors++; $display("FAIL bp_ready act=ready_or_idle exp=in_ready0 busy1"); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_transfer act=vld%b rdy%b busy%b exp=vld0 rdy1 busy0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]   pt_v [3];
    logic [KW-1:0] key_v [3];
    logic [63:0]   exp_v [3];
    int t_done [3];
    int r_exp, n;
    bit r_ok;
`ifdef PRESENT_KEY128_EN
    for (int j = 0; j < 3; j++) begin pt_v[j] = '0; key_v[j] = '0; exp_v[j] = EXP_ZERO; end
`else
    pt_v[0] = '0; key_v[0] = '0; exp_v[0] = EXP_ZERO;
    pt_v[1] = '1; key_v[1] = '0; exp_v[1] = 64'hA112_FFC7_2F68_417B;
    pt_v[2] = '0; key_v[2] = '1; exp_v[2] = 64'hE72C_46C0_F594_5049;
`endif
    @(negedge clk);
    data_i = pt_v[0]; key_i = key_v[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      r_exp = 1; r_ok = 1'b1; n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        @(posedge clk); @(negedge clk); n++;
        if (busy === 1'b1 && out_valid !== 1'b1) begin
          if (round !== 5'(r_exp)) r_ok = 1'b0;
          r_exp++;
        end
      end
      t_done[j] = cyc;
      checks++; if (data_o !== exp_v[j]) begin errors++; $display("FAIL b2b_data%0d act=%h exp=%h", j, data_o, exp_v[j]); end
      checks++;
      if (!r_ok || r_exp != 32) begin
        errors++;
        $display("FAIL b2b_rounds%0d act=ok%0d next%0d exp=ok1 next32", j, r_ok, r_exp);
      end
      if (j > 0) begin
        checks++;
        if (t_done[j] - t_done[j-1] != 33) begin
          errors++;
          $display("FAIL b2b_period%0d act=%0d exp=33", j, t_done[j] - t_done[j-1]);
        end
      end
      if (j < 2) begin
        data_i = pt_v[j+1]; key_i = key_v[j+1];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    data_i = '1; key_i = '1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round !== 5'd15 && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    checks++; if (round !== 5'd15) begin errors++; $display("FAIL ar_reach15 act=%0d exp=15", round); end
    // Reset lands between edges; outputs must clear before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_o !== 64'h0 || busy !== 1'b0 || round !== 5'd0) begin
      errors++;
      $display("FAIL ar_clear act=rdy%b vld%b busy%b round%0d data%h exp=rdy1 vld0 busy0 round0 data0",
               in_ready, out_valid, busy, round, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_no_partial act=vld%b busy%b exp=vld0 busy0", out_valid, busy);
    end
`ifdef PRESENT_KEY128_EN
    do_job(64'h0, '0, EXP_ZERO, "ar_job");
`else
    do_job('1, '1, 64'h3333_DCD3_2132_10D2, "ar_job");
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present_enc_ctrl.md
Name: present_enc_ctrl

Overview:
Iterative PRESENT-80 encryption controller that schedules 31 rounds of addRoundKey, sBoxLayer and pLayer onto one shared round datapath, one round per clock. It instantiates the existing 64-bit permutation layer and a 16-entry S-box, and runs the key schedule alongside. Input and output use valid/ready handshakes, so it sits between a plaintext/key source and a ciphertext sink.

Parameters:
ROUNDS, 31, number of full rounds; the final key whitening is added after the last round. Fixed by the standard; RTL asserts ROUNDS==31.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
in_valid_i  input  1  plaintext/key valid
in_ready_o  output  1  block can accept a new job
data_i  input  64  plaintext
key_i  input  KW  cipher key; KW=80, or 128 with PRESENT_KEY128_EN
out_valid_o  output  1  ciphertext valid
out_ready_i  input  1  sink accepts ciphertext
data_o  output  64  ciphertext; forced to 0 when out_valid_o=0
busy_o  output  1  high in RUN or DONE
round_o  output  5  current round counter; 0 in IDLE

Behaviour:
- Clocking: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset: state=IDLE, in_ready_o=1, out_valid_o=0, data_o=0, busy_o=0, round_o=0, state_q=0, key_q=0, cnt_q=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: state_q<=data_i, key_q<=key_i, cnt_q<=1, go to RUN.
  - in_valid_i is ignored outside IDLE.
- RUN, one round per cycle:
  - rk = key_q[KW-1:KW-64].
  - state_q <= P(S(state_q ^ rk)), where S applies the S-box to every nibble and P is the permutation-layer instance.
  - key_q <= KS(key_q, cnt_q); cnt_q <= cnt_q+1.
  - When cnt_q==31, go to DONE. cnt_q ends at 32, truncated to 5 bits.
- S-box for input 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- KS for 80-bit keys:
  - Rotate left by 61.
  - S-box on bits [79:76].
  - XOR the 5-bit counter into bits [19:15].
- DONE:
  - out_valid_o=1.
  - data_o = state_q ^ key_q[KW-1:KW-64] (K32 whitening, combinational from registers).
  - Hold data_o stable until out_ready_i.
  - On out_valid_o&out_ready_i: go to IDLE, cnt_q<=0.
- Latency: handshake accepted at edge t; out_valid_o is high after edge t+31. Minimum job period is 32 cycles plus 1 cycle in IDLE, so 33 cycles with out_ready_i tied high.
- Backpressure: DONE holds indefinitely; in_ready_o stays 0.
- round_o = cnt_q in RUN, 0 otherwise; busy_o = (state!=IDLE).
- Reset asserted mid-RUN or mid-DONE: immediately aborts to reset values. No partial result is emitted.
- Counter overflow cannot occur: exit at 31 is fixed.

Optional Feature:
PRESENT_KEY128_EN
- Defined:
  - KW=128; key_i and key_q are 128 bits.
  - KS: rotate left 61; S-box on [127:124] and [123:120]; XOR the counter into [66:62].
  - rk = key_q[127:64].
- Undefined: KW=80 with the 80-bit schedule above.
- FSM, latency and handshakes are identical in both builds.

Test Plan:
- 80-bit build, pt=0, key=0 -> data_o=5579C1387B228445, out_valid_o rises exactly 32 edges after accept.
- 80-bit build, pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049. pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B. pt=all-ones, key=all-ones -> 3333DCD3213210D2.
- Backpressure:
  - Hold out_ready_i=0 for 20 cycles after out_valid_o: data_o stable, in_ready_o=0, in_valid_i pulses ignored.
  - Then out_ready_i=1: one-cycle transfer, in_ready_o=1 the next cycle.
- Back-to-back jobs with in_valid_i and out_ready_i held high: results in order, 33-cycle period, round_o steps 1..31.
- Assert rst_n_i at round 15 asynchronously (mid-cycle): all outputs reach reset values without a clock edge. A new job after release gives the correct ciphertext.
- PRESENT_KEY128_EN build, pt=0, key=0 -> 96DB702A2E6900AF, same latency as the 80-bit build.
